ysyx_24110015_mem_arbiter: RTL and testbench
============================================

# ysyx_24110015_mem_arbiter

Sequential arbiter that shares the single DPI-backed memory port between the instruction-fetch requester (IFU, read-only) and the load/store requester (LSU, read/write). It replaces the direct, combinational fetch path with a valid/ready request channel, one outstanding transaction, and a registered one-cycle response pulse. It sits between IFU/LSU and the memory-access wrapper that issues `pmem_read`/`pmem_write`.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; write mask width is DATA_W/8

- clk  input  1  clock
- rst  input  1  reset; synchronous, active-low (asserted when 0)
- ifu_req_valid  input  1  IFU fetch request
- ifu_req_ready  output  1  IFU request accepted this cycle
- ifu_addr  input  ADDR_W  fetch address
- ifu_resp_valid  output  1  one-cycle fetch response pulse
- ifu_rdata  output  DATA_W  fetched instruction
- lsu_req_valid  input  1  LSU request
- lsu_req_ready  output  1  LSU request accepted this cycle
- lsu_addr  input  ADDR_W  access address
- lsu_wen  input  1  1 = write, 0 = read
- lsu_wdata  input  DATA_W  write data
- lsu_wmask  input  DATA_W/8  byte write mask
- lsu_resp_valid  output  1  one-cycle response pulse (read data or write ack)
- lsu_rdata  output  DATA_W  read data; 0 for write acks
- mem_req_valid  output  1  downstream request
- mem_req_ready  input  1  downstream accepts request
- mem_addr, mem_wen, mem_wdata, mem_wmask  output  ADDR_W/1/DATA_W/DATA_W/8  registered request fields
- mem_resp_valid  input  1  downstream response
- mem_rdata  input  DATA_W  downstream read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, pick a winner; the winner's req_ready = 1 combinationally in this cycle (the loser's = 0). On the handshake, latch addr/wen/wdata/wmask and the owner id (IFU requests latch wen = 0, wmask = 0) and go to ISSUE.
- ISSUE: mem_req_valid = 1 with the latched fields. On mem_req_ready, go to WAIT. Fields stay stable until accepted.
- WAIT: on mem_resp_valid, capture mem_rdata (or 0 if wen) and go to RESP.
- RESP: the owner's resp_valid = 1 for exactly one cycle with the captured data. Go to IDLE.
- req_ready is 0 in every state except IDLE, so there is at most one outstanding transaction.
- mem_resp_valid outside WAIT is ignored.
- Default arbitration is fixed priority: LSU wins over IFU on a tie.
- Reset: state = IDLE; all outputs = 0; latched fields, captured data and owner cleared. Any in-flight transaction is dropped and no response is emitted for it.

## Timing
- Minimum round trip is 3 cycles after the accept edge.
  - Cycle 0: handshake.
  - Cycle 1: ISSUE with mem_req_ready = 1.
  - Cycle 2: WAIT with mem_resp_valid = 1.
  - Cycle 3: resp_valid.
- Each cycle mem_req_ready is held low adds one cycle; each cycle of downstream response latency adds one cycle.
- The next request can be accepted in the cycle after RESP (IDLE), so back-to-back throughput is 1 transaction per 4 cycles.
- Requesters must accept resp_valid unconditionally; there is no response backpressure.

## Configuration
- YSYX_ARB_RR_EN defined: round-robin arbitration. A 1-bit last-served register is updated on every grant. On a tie, the requester not last served wins. The register's reset value is "LSU", so IFU wins the first tie after reset.
- YSYX_ARB_RR_EN undefined: fixed LSU priority, and no last-served register is present.

## Structure
- Package ysyx_24110015_arb_pkg holds:
  - the FSM state enum (IDLE/ISSUE/WAIT/RESP);
  - the owner id encoding (OWN_IFU = 0, OWN_LSU = 1);
  - the MASK_W = DATA_W/8 constant.
- Sub-module ysyx_24110015_arb_pick contains the pure grant logic: inputs are both valids and last_served; output is the winner id. It holds the fixed-priority vs round-robin selection under the macro.

## Test plan
- IFU read alone, addr 0x8000_0000; mem ready immediately, mem_rdata 0x0000_0413 one cycle after accept → ifu_resp_valid pulses at accept+3 with 0x0000_0413; lsu_resp_valid stays 0.
- IFU and LSU valid in the same cycle (LSU read 0x8000_0100) → without the macro: LSU granted first, IFU served after LSU RESP. With YSYX_ARB_RR_EN after reset: IFU first, then LSU; a second tie goes to the other requester.
- LSU write 0x8000_0200, wdata 0xDEAD_BEEF, wmask 0xF; mem_req_ready held low 2 cycles → mem fields stable throughout ISSUE; lsu_resp_valid with lsu_rdata = 0 at accept+5.
- Spurious mem_resp_valid while in IDLE and ISSUE → no resp_valid on either requester; FSM state unchanged.
- rst = 0 during WAIT → next cycle IDLE, all outputs 0; a later mem_resp_valid is ignored; a fresh IFU request completes normally.

Source files
------------

// File: rtl/ysyx_24110015_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
// Round-robin arbitration is enabled by defining YSYX_ARB_RR_EN.
package ysyx_24110015_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  // Requester that was not the given one; used for round-robin tie breaking.
  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_LSU) ? OWN_IFU : OWN_LSU;
  endfunction

endpackage

// File: rtl/ysyx_24110015_mem_arbiter_if.sv
// Bus bundle between IFU/LSU requesters, the arbiter and the memory-access wrapper.
// slave = arbiter view, master = environment (requesters + memory) view.
interface ysyx_24110015_mem_arbiter_if;
  import ysyx_24110015_arb_pkg::*;

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_rdata;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [MASK_W-1:0] lsu_wmask;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_rdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );

endinterface

// File: rtl/ysyx_24110015_arb_pick.sv
// Pure grant selection between IFU and LSU.
// Fixed LSU priority by default; round-robin when YSYX_ARB_RR_EN is defined.
module ysyx_24110015_arb_pick
  import ysyx_24110015_arb_pkg::*;
(
  input  logic   ifu_valid,
  input  logic   lsu_valid,
  input  owner_t last_served,
  output owner_t winner
);

`ifdef YSYX_ARB_RR_EN
  // On a tie the requester not served last wins.
  always_comb begin
    winner = OWN_LSU;
    if (ifu_valid && lsu_valid) begin
      winner = other_owner(last_served);
    end else if (ifu_valid) begin
      winner = OWN_IFU;
    end else begin
      winner = OWN_LSU;
    end
  end
`else
  logic unused_last_served_s;
  assign unused_last_served_s = last_served;

  // LSU always wins a tie.
  always_comb begin
    winner = OWN_LSU;
    if (lsu_valid) begin
      winner = OWN_LSU;
    end else if (ifu_valid) begin
      winner = OWN_IFU;
    end else begin
      winner = OWN_LSU;
    end
  end
`endif

endmodule

// File: rtl/ysyx_24110015_mem_arbiter.sv
// Shares one memory port between IFU and LSU: one outstanding transaction,
// registered request fields and a one-cycle response pulse. Macro: YSYX_ARB_RR_EN.
module ysyx_24110015_mem_arbiter
  import ysyx_24110015_arb_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  ysyx_24110015_mem_arbiter_if.slave  bus
);

  arb_state_t        state_r;
  owner_t            owner_r;
  logic [ADDR_W-1:0] addr_r;
  logic              wen_r;
  logic [DATA_W-1:0] wdata_r;
  logic [MASK_W-1:0] wmask_r;
  logic              mem_req_valid_r;
  logic              ifu_resp_valid_r;
  logic              lsu_resp_valid_r;
  logic [DATA_W-1:0] ifu_rdata_r;
  logic [DATA_W-1:0] lsu_rdata_r;

  owner_t            winner_s;
  owner_t            last_served_s;
  logic              ifu_ready_s;
  logic              lsu_ready_s;
  logic              grant_s;

  ysyx_24110015_arb_pick u_pick (
    .ifu_valid   (bus.ifu_req_valid),
    .lsu_valid   (bus.lsu_req_valid),
    .last_served (last_served_s),
    .winner      (winner_s)
  );

`ifdef YSYX_ARB_RR_EN
  owner_t last_served_r;

  // Remembers who got the most recent grant; starts as LSU so IFU wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_served_r <= OWN_LSU;
    end else if (grant_s) begin
      last_served_r <= winner_s;
    end
  end

  assign last_served_s = last_served_r;
`else
  assign last_served_s = OWN_LSU;
`endif

  // Requests are only accepted in IDLE and never while reset is asserted.
  always_comb begin
    ifu_ready_s = 1'b0;
    lsu_ready_s = 1'b0;
    if (rst && (state_r == IDLE)) begin
      ifu_ready_s = bus.ifu_req_valid && (winner_s == OWN_IFU);
      lsu_ready_s = bus.lsu_req_valid && (winner_s == OWN_LSU);
    end else begin
      ifu_ready_s = 1'b0;
      lsu_ready_s = 1'b0;
    end
  end

  assign grant_s = ifu_ready_s | lsu_ready_s;

  // Transaction FSM with all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r          <= IDLE;
      owner_r          <= OWN_IFU;
      addr_r           <= {ADDR_W{1'b0}};
      wen_r            <= 1'b0;
      wdata_r          <= {DATA_W{1'b0}};
      wmask_r          <= {MASK_W{1'b0}};
      mem_req_valid_r  <= 1'b0;
      ifu_resp_valid_r <= 1'b0;
      lsu_resp_valid_r <= 1'b0;
      ifu_rdata_r      <= {DATA_W{1'b0}};
      lsu_rdata_r      <= {DATA_W{1'b0}};
    end else begin
      ifu_resp_valid_r <= 1'b0;
      lsu_resp_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (lsu_ready_s) begin
            owner_r         <= OWN_LSU;
            addr_r          <= bus.lsu_addr;
            wen_r           <= bus.lsu_wen;
            wdata_r         <= bus.lsu_wdata;
            wmask_r         <= bus.lsu_wmask;
            mem_req_valid_r <= 1'b1;
            state_r         <= ISSUE;
          end else if (ifu_ready_s) begin
            owner_r         <= OWN_IFU;
            addr_r          <= bus.ifu_addr;
            wen_r           <= 1'b0;
            wdata_r         <= {DATA_W{1'b0}};
            wmask_r         <= {MASK_W{1'b0}};
            mem_req_valid_r <= 1'b1;
            state_r         <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_r <= 1'b0;
            state_r         <= WAIT;
          end else begin
            state_r <= ISSUE;
          end
        end
        WAIT: begin
          if (bus.mem_resp_valid) begin
            // Write acks return zero data to the owner.
            if (owner_r == OWN_LSU) begin
              lsu_resp_valid_r <= 1'b1;
              lsu_rdata_r      <= wen_r ? {DATA_W{1'b0}} : bus.mem_rdata;
            end else begin
              ifu_resp_valid_r <= 1'b1;
              ifu_rdata_r      <= bus.mem_rdata;
            end
            state_r <= RESP;
          end else begin
            state_r <= WAIT;
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.ifu_req_ready  = ifu_ready_s;
  assign bus.lsu_req_ready  = lsu_ready_s;
  assign bus.ifu_resp_valid = ifu_resp_valid_r;
  assign bus.ifu_rdata      = ifu_rdata_r;
  assign bus.lsu_resp_valid = lsu_resp_valid_r;
  assign bus.lsu_rdata      = lsu_rdata_r;
  assign bus.mem_req_valid  = mem_req_valid_r;
  assign bus.mem_addr       = addr_r;
  assign bus.mem_wen        = wen_r;
  assign bus.mem_wdata      = wdata_r;
  assign bus.mem_wmask      = wmask_r;

endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
// Directed self-checking bench for ysyx_24110015_mem_arbiter (fixed or YSYX_ARB_RR_EN build).
module tb_ysyx_24110015_mem_arbiter;
  import ysyx_24110015_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef YSYX_ARB_RR_EN
  localparam logic TIE1_LSU = 1'b0;
`else
  localparam logic TIE1_LSU = 1'b1;
`endif
  localparam logic TIE2_LSU = 1'b1;

  always #5 clk = ~clk;

  ysyx_24110015_mem_arbiter_if bus();

  ysyx_24110015_mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_addr       = 32'h0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_addr       = 32'h0;
    bus.lsu_wen        = 1'b0;
    bus.lsu_wdata      = 32'h0;
    bus.lsu_wmask      = 4'h0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = 32'h0;
  endtask

  // Called in the ISSUE cycle; returns in the RESP cycle.
  task automatic mem_serve(input logic [31:0] data);
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = data;
    cyc();
    bus.mem_resp_valid = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    logic [140:0] obs;
    rst = 1'b0;
    idle_inputs();
    bus.ifu_req_valid = 1'b1;
    bus.lsu_req_valid = 1'b1;
    repeat (3) cyc();
    settle();
    obs = {bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid, bus.ifu_resp_valid,
           bus.lsu_resp_valid, bus.mem_wen, bus.mem_wmask, bus.mem_addr, bus.mem_wdata,
           bus.ifu_rdata, bus.lsu_rdata, 3'b000};
    n_cmp++;
    if (obs !== 141'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", obs);
    end
    rst = 1'b1;
    idle_inputs();
    cyc();
  endtask

  task automatic test_ifu_read();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0000;
    settle();
    n_cmp++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL ifu_accept: got %b want 10", {bus.ifu_req_ready, bus.lsu_req_ready});
    end
    cyc();
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    settle();
    n_cmp++;
    if ({bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wmask} !== {1'b1, 32'h8000_0000, 1'b0, 4'h0}) begin
      n_bad++;
      $display("FAIL ifu_issue: got v=%b a=%h w=%b m=%h want v=1 a=80000000 w=0 m=0",
               bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wmask);
    end
    cyc();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h0000_0413;
    settle();
    n_cmp++;
    if ({bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL ifu_wait: got %b want 000", {bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid});
    end
    cyc();
    bus.mem_resp_valid = 1'b0;
    settle();
    n_cmp++;
    if ({bus.ifu_resp_valid, bus.ifu_rdata, bus.lsu_resp_valid} !== {1'b1, 32'h0000_0413, 1'b0}) begin
      n_bad++;
      $display("FAIL ifu_resp: got v=%b d=%h lsu=%b want v=1 d=00000413 lsu=0",
               bus.ifu_resp_valid, bus.ifu_rdata, bus.lsu_resp_valid);
    end
    cyc();
    n_cmp++;
    if ({bus.ifu_resp_valid, bus.lsu_resp_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL ifu_resp_pulse: got %b want 00", {bus.ifu_resp_valid, bus.lsu_resp_valid});
    end
  endtask

  task automatic test_tie();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0004;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_0100;
    bus.lsu_wen       = 1'b0;
    settle();
    n_cmp++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== (TIE1_LSU ? 2'b01 : 2'b10)) begin
      n_bad++;
      $display("FAIL tie1_grant: got %b want %b", {bus.ifu_req_ready, bus.lsu_req_ready}, TIE1_LSU ? 2'b01 : 2'b10);
    end
    cyc();
    settle();
    n_cmp++;
    if (bus.mem_addr !== (TIE1_LSU ? 32'h8000_0100 : 32'h8000_0004)) begin
      n_bad++;
      $display("FAIL tie1_addr: got %h want %h", bus.mem_addr, TIE1_LSU ? 32'h8000_0100 : 32'h8000_0004);
    end
    mem_serve(32'hA1A1_A1A1);
    n_cmp++;
    if ({bus.ifu_resp_valid, bus.lsu_resp_valid, (TIE1_LSU ? bus.lsu_rdata : bus.ifu_rdata)} !==
        {~TIE1_LSU, TIE1_LSU, 32'hA1A1_A1A1}) begin
      n_bad++;
      $display("FAIL tie1_resp: got i=%b l=%b il=%h ld=%h want winner data a1a1a1a1",
               bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_rdata, bus.lsu_rdata);
    end
    n_cmp++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL ready_in_resp: got %b want 00", {bus.ifu_req_ready, bus.lsu_req_ready});
    end
    cyc();
    n_cmp++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== (TIE2_LSU ? 2'b01 : 2'b10)) begin
      n_bad++;
      $display("FAIL tie2_grant: got %b want %b", {bus.ifu_req_ready, bus.lsu_req_ready}, TIE2_LSU ? 2'b01 : 2'b10);
    end
    cyc();
    bus.lsu_req_valid = 1'b0;
    settle();
    n_cmp++;
    if (bus.mem_addr !== 32'h8000_0100) begin
      n_bad++;
      $display("FAIL tie2_addr: got %h want 80000100", bus.mem_addr);
    end
    mem_serve(32'hB2B2_B2B2);
    n_cmp++;
    if ({bus.lsu_resp_valid, bus.lsu_rdata, bus.ifu_resp_valid} !== {1'b1, 32'hB2B2_B2B2, 1'b0}) begin
      n_bad++;
      $display("FAIL tie2_resp: got v=%b d=%h i=%b want v=1 d=b2b2b2b2 i=0",
               bus.lsu_resp_valid, bus.lsu_rdata, bus.ifu_resp_valid);
    end
    cyc();
    n_cmp++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL ifu_after_lsu_grant: got %b want 10", {bus.ifu_req_ready, bus.lsu_req_ready});
    end
    cyc();
    bus.ifu_req_valid = 1'b0;
    mem_serve(32'hC3C3_C3C3);
    n_cmp++;
    if ({bus.ifu_resp_valid, bus.ifu_rdata, bus.lsu_resp_valid} !== {1'b1, 32'hC3C3_C3C3, 1'b0}) begin
      n_bad++;
      $display("FAIL ifu_after_lsu_resp: got v=%b d=%h l=%b want v=1 d=c3c3c3c3 l=0",
               bus.ifu_resp_valid, bus.ifu_rdata, bus.lsu_resp_valid);
    end
    cyc();
  endtask

  task automatic test_lsu_write_stall();
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_0200;
    bus.lsu_wen       = 1'b1;
    bus.lsu_wdata     = 32'hDEAD_BEEF;
    bus.lsu_wmask     = 4'hF;
    settle();
    n_cmp++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL lsu_write_accept: got %b want 01", {bus.ifu_req_ready, bus.lsu_req_ready});
    end
    cyc();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      bus.mem_req_ready = (i == 2) ? 1'b1 : 1'b0;
      settle();
      n_cmp++;
      if ({bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask} !==
          {1'b1, 32'h8000_0200, 1'b1, 32'hDEAD_BEEF, 4'hF}) begin
        n_bad++;
        $display("FAIL write_fields_stable[%0d]: got v=%b a=%h w=%b d=%h m=%h want v=1 a=80000200 w=1 d=deadbeef m=f",
                 i, bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask);
      end
      cyc();
    end
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h1234_5678;
    settle();
    n_cmp++;
    if ({bus.mem_req_valid, bus.lsu_resp_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL write_wait: got %b want 00", {bus.mem_req_valid, bus.lsu_resp_valid});
    end
    cyc();
    bus.mem_resp_valid = 1'b0;
    settle();
    n_cmp++;
    if ({bus.lsu_resp_valid, bus.lsu_rdata, bus.ifu_resp_valid} !== {1'b1, 32'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL write_ack: got v=%b d=%h i=%b want v=1 d=00000000 i=0",
               bus.lsu_resp_valid, bus.lsu_rdata, bus.ifu_resp_valid);
    end
    cyc();
  endtask

  task automatic test_spurious_resp();
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h5555_5555;
    cyc();
    bus.mem_resp_valid = 1'b0;
    settle();
    n_cmp++;
    if ({bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_req_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL spurious_idle: got %b want 000", {bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_req_valid});
    end
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0008;
    settle();
    n_cmp++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL spurious_idle_state: got %b want 10", {bus.ifu_req_ready, bus.lsu_req_ready});
    end
    cyc();
    bus.ifu_req_valid  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h6666_6666;
    cyc();
    bus.mem_resp_valid = 1'b0;
    settle();
    n_cmp++;
    if ({bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid} !== 3'b100) begin
      n_bad++;
      $display("FAIL spurious_issue: got %b want 100", {bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid});
    end
    mem_serve(32'h7777_7777);
    n_cmp++;
    if ({bus.ifu_resp_valid, bus.ifu_rdata} !== {1'b1, 32'h7777_7777}) begin
      n_bad++;
      $display("FAIL spurious_then_normal: got v=%b d=%h want v=1 d=77777777", bus.ifu_resp_valid, bus.ifu_rdata);
    end
    cyc();
  endtask

  task automatic test_reset_in_wait();
    logic [140:0] obs;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_000C;
    cyc();
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    settle();
    obs = {bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid, bus.ifu_resp_valid,
           bus.lsu_resp_valid, bus.mem_wen, bus.mem_wmask, bus.mem_addr, bus.mem_wdata,
           bus.ifu_rdata, bus.lsu_rdata, 3'b000};
    n_cmp++;
    if (obs !== 141'h0) begin
      n_bad++;
      $display("FAIL reset_in_wait: got %h want 0", obs);
    end
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h9999_9999;
    cyc();
    bus.mem_resp_valid = 1'b0;
    cyc();
    n_cmp++;
    if ({bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_rdata} !== {2'b00, 32'h0}) begin
      n_bad++;
      $display("FAIL late_resp_ignored: got i=%b l=%b d=%h want 0 0 0", bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_rdata);
    end
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0010;
    settle();
    n_cmp++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL post_reset_accept: got %b want 10", {bus.ifu_req_ready, bus.lsu_req_ready});
    end
    cyc();
    bus.ifu_req_valid = 1'b0;
    settle();
    n_cmp++;
    if ({bus.mem_req_valid, bus.mem_addr} !== {1'b1, 32'h8000_0010}) begin
      n_bad++;
      $display("FAIL post_reset_issue: got v=%b a=%h want v=1 a=80000010", bus.mem_req_valid, bus.mem_addr);
    end
    mem_serve(32'h0000_0513);
    n_cmp++;
    if ({bus.ifu_resp_valid, bus.ifu_rdata, bus.lsu_resp_valid} !== {1'b1, 32'h0000_0513, 1'b0}) begin
      n_bad++;
      $display("FAIL post_reset_resp: got v=%b d=%h l=%b want v=1 d=00000513 l=0",
               bus.ifu_resp_valid, bus.ifu_rdata, bus.lsu_resp_valid);
    end
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ifu_read();
    test_reset();
    test_tie();
    test_lsu_write_stall();
    test_spurious_resp();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
